pe_ctx_sequencer: RTL

PE_CTX_SEQUENCER -- requirements
Module: pe_ctx_sequencer

---
 rtl/pe_ctx_sequencer_pkg.sv | 104 ++++++++++
 rtl/pe_ctx_mem.sv | 37 +++
 rtl/pe_ctx_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ctx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pe_ctx_sequencer_pkg
// Shared definitions for the PE context sequencer:
//   - sequencer FSM state encoding
//   - bit positions of every field inside a 59-bit context word
//   - decoded control bundle type and its idle value
//   - helpers to unpack a context word and to present it to the PE
// ---------------------------------------------------------------------------
package pe_ctx_sequencer_pkg;

  localparam int CTX_W = 59;

  // Context word field positions, MSB first.
  localparam int CI_MSB  = 58;  localparam int CI_LSB  = 50;  // control_in
  localparam int CO_MSB  = 49;  localparam int CO_LSB  = 41;  // control_out
  localparam int PI_MSB  = 40;  localparam int PI_LSB  = 35;  // control_put_in
  localparam int PO_MSB  = 34;  localparam int PO_LSB  = 29;  // control_put_out
  localparam int R1_MSB  = 28;  localparam int R1_LSB  = 23;  // control_reg_1
  localparam int R2_MSB  = 22;  localparam int R2_LSB  = 17;  // control_reg_2
  localparam int SD_MSB  = 16;  localparam int SD_LSB  = 11;  // control_send
  localparam int F1_MSB  = 10;  localparam int F1_LSB  = 7;   // control_pe2fu_1
  localparam int F2_MSB  = 6;   localparam int F2_LSB  = 3;   // control_pe2fu_2
  localparam int WB_BIT  = 2;                                 // wb_en
  localparam int LD_BIT  = 1;                                 // ld
  localparam int LDW_BIT = 0;                                 // ld_write

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Decoded control bundle; field order mirrors the context word so the
  // bundle packs back to the same 59 bits.
  typedef struct packed {
    logic [8:0] control_in;
    logic [8:0] control_out;
    logic [5:0] control_put_in;
    logic [5:0] control_put_out;
    logic [5:0] control_reg_1;
    logic [5:0] control_reg_2;
    logic [5:0] control_send;
    logic [3:0] control_pe2fu_1;
    logic [3:0] control_pe2fu_2;
    logic       wb_en;
    logic       ld;
    logic       ld_write;
  } pe_ctrl_t;

  // Idle value: no selects, no write-back, register file loads its own
  // contents (ld = 1, ld_write = 0) so it simply holds.
  localparam pe_ctrl_t CTRL_IDLE = '{
    control_in:      9'd0,
    control_out:     9'd0,
    control_put_in:  6'd0,
    control_put_out: 6'd0,
    control_reg_1:   6'd0,
    control_reg_2:   6'd0,
    control_send:    6'd0,
    control_pe2fu_1: 4'd0,
    control_pe2fu_2: 4'd0,
    wb_en:           1'b0,
    ld:              1'b1,
    ld_write:        1'b0
  };

  function automatic pe_ctrl_t ctx_unpack(input logic [CTX_W-1:0] w);
    pe_ctrl_t c;
    c.control_in      = w[CI_MSB:CI_LSB];
    c.control_out     = w[CO_MSB:CO_LSB];
    c.control_put_in  = w[PI_MSB:PI_LSB];
    c.control_put_out = w[PO_MSB:PO_LSB];
    c.control_reg_1   = w[R1_MSB:R1_LSB];
    c.control_reg_2   = w[R2_MSB:R2_LSB];
    c.control_send    = w[SD_MSB:SD_LSB];
    c.control_pe2fu_1 = w[F1_MSB:F1_LSB];
    c.control_pe2fu_2 = w[F2_MSB:F2_LSB];
    c.wb_en           = w[WB_BIT];
    c.ld              = w[LD_BIT];
    c.ld_write        = w[LDW_BIT];
    return c;
  endfunction

  // Context as driven to the PE: write-back is qualified by the FU predicate
  // sampled on the same edge that loads the context.
  function automatic pe_ctrl_t ctx_present(input logic [CTX_W-1:0] w,
                                           input logic             pred);
    pe_ctrl_t c;
    c       = ctx_unpack(w);
    c.wb_en = c.wb_en & pred;
    return c;
  endfunction

  // Stall view of a presented context: selects kept, register file held.
  function automatic pe_ctrl_t ctx_hold(input pe_ctrl_t cur);
    pe_ctrl_t c;
    c          = cur;
    c.wb_en    = 1'b0;
    c.ld       = 1'b1;
    c.ld_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// ---------------------------------------------------------------------------
// pe_ctx_mem
// Context storage: DEPTH x 59-bit register array, one synchronous write port,
// one asynchronous read port. Contents are never reset, so programmed
// contexts survive a sequencer reset.
//   CLK    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data (context word)
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
// ---------------------------------------------------------------------------
module pe_ctx_mem
  import pe_ctx_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CTX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CTX_W-1:0] rdata
);

  logic [CTX_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// ---------------------------------------------------------------------------
// pe_ctx_sequencer
// Steps a PE through a programmed list of context words, ctx_len contexts per
// iteration for iter_cnt iterations, driving registered PE control outputs.
//   CLK, RST                   clock, asynchronous active-high reset
//   ctx_we/ctx_waddr/ctx_wdata context write port (accepted outside RUN)
//   start, ctx_len, iter_cnt   launch request and its run parameters
//   stall                      freeze sequencing, register file holds
//   abort                      end the run immediately, no done pulse
//   pred_in                    FU predicate qualifying write_back
//   control_* outputs          PE mux/demux selects and register indices
//   write_back, ld, ld_write   PE register write enables
//   busy                       high while running
//   done, cfg_err              one-cycle pulses: run complete / bad request
// ---------------------------------------------------------------------------
module pe_ctx_sequencer
  import pe_ctx_sequencer_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ctx_we,
  input  logic [CTX_AW-1:0] ctx_waddr,
  input  logic [CTX_W-1:0]  ctx_wdata,
  input  logic              start,
  input  logic [CTX_AW:0]   ctx_len,
  input  logic [7:0]        iter_cnt,
  input  logic              stall,
  input  logic              abort,
  input  logic              pred_in,
  output logic [8:0]        control_in,
  output logic [8:0]        control_out,
  output logic [5:0]        control_put_in,
  output logic [5:0]        control_put_out,
  output logic [5:0]        control_reg_1,
  output logic [5:0]        control_reg_2,
  output logic [5:0]        control_send,
  output logic [3:0]        control_pe2fu_1,
  output logic [3:0]        control_pe2fu_2,
  output logic              write_back,
  output logic              ld,
  output logic              ld_write,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [CTX_AW-1:0] PC_ONE  = CTX_AW'(1);
  localparam logic [CTX_AW:0]   LEN_ONE = (CTX_AW+1)'(1);
  localparam logic [CTX_AW:0]   DEPTH_V = (CTX_AW+1)'(CTX_DEPTH);

  seq_state_t        state_reg, state_next;
  logic [CTX_AW-1:0] pc_reg,    pc_next;
  logic [CTX_AW:0]   len_reg,   len_next;
  logic [7:0]        iter_reg,  iter_next;
  pe_ctrl_t          ctrl_reg,  ctrl_next;
  logic              done_reg,  done_next;
  logic              cfg_err_reg, cfg_err_next;

  logic [CTX_W-1:0]  rd_data;
  logic              mem_we;
  logic              start_ok;
  logic              pc_wrap;
  logic              run_end;

  // -------------------------------------------------------------------------
  // Context memory. pc_reg is 0 whenever the sequencer is idle, so the same
  // read address serves both the launch (ctx[0]) and the running case.
  // -------------------------------------------------------------------------
  assign mem_we = ctx_we && (state_reg != ST_RUN);

  pe_ctx_mem #(
    .DEPTH (CTX_DEPTH),
    .AW    (CTX_AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (ctx_waddr),
    .wdata (ctx_wdata),
    .raddr (pc_reg),
    .rdata (rd_data)
  );

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------
  assign start_ok = (ctx_len != '0) && (ctx_len <= DEPTH_V) && (iter_cnt != 8'd0);

  // pc points at the context to load next; it is the last of the iteration
  // when it equals ctx_len-1.
  assign pc_wrap  = ({1'b0, pc_reg} == (len_reg - LEN_ONE));

  // pc back at 0 means the context currently on the outputs closed an
  // iteration; iter_reg still counts that iteration, so 1 means the run
  // has fully presented its last context.
  assign run_end  = (pc_reg == '0) && (iter_reg == 8'd1);

  // -------------------------------------------------------------------------
  // State register (with the datapath registers it sequences)
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      len_reg     <= '0;
      iter_reg    <= 8'd0;
      ctrl_reg    <= CTRL_IDLE;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      len_reg     <= len_next;
      iter_reg    <= iter_next;
      ctrl_reg    <= ctrl_next;
      done_reg    <= done_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (!abort && start && start_ok) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!stall && run_end) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    pc_next      = pc_reg;
    len_next     = len_reg;
    iter_next    = iter_reg;
    ctrl_next    = CTRL_IDLE;
    done_next    = 1'b0;
    // A context write that arrives while running is dropped and flagged.
    cfg_err_next = ctx_we && (state_reg == ST_RUN);

    unique case (state_reg)
      ST_IDLE: begin
        if (!abort && start) begin
          if (start_ok) begin
            ctrl_next = ctx_present(rd_data, pred_in);
            pc_next   = (ctx_len == LEN_ONE) ? '0 : PC_ONE;
            len_next  = ctx_len;
            iter_next = iter_cnt;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          pc_next   = '0;
          iter_next = 8'd0;
        end else if (stall) begin
          ctrl_next = ctx_hold(ctrl_reg);
        end else if (run_end) begin
          pc_next   = '0;
          iter_next = 8'd0;
          done_next = 1'b1;
        end else begin
          ctrl_next = ctx_present(rd_data, pred_in);
          pc_next   = pc_wrap ? '0 : (pc_reg + PC_ONE);
          // Loading ctx[0] while running starts a new iteration.
          if (pc_reg == '0) begin
            iter_next = iter_reg - 8'd1;
          end
        end
      end

      ST_DONE: begin
        pc_next   = '0;
        iter_next = 8'd0;
      end

      default: begin
        pc_next   = '0;
        iter_next = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output drive (all from registers)
  // -------------------------------------------------------------------------
  assign control_in      = ctrl_reg.control_in;
  assign control_out     = ctrl_reg.control_out;
  assign control_put_in  = ctrl_reg.control_put_in;
  assign control_put_out = ctrl_reg.control_put_out;
  assign control_reg_1   = ctrl_reg.control_reg_1;
  assign control_reg_2   = ctrl_reg.control_reg_2;
  assign control_send    = ctrl_reg.control_send;
  assign control_pe2fu_1 = ctrl_reg.control_pe2fu_1;
  assign control_pe2fu_2 = ctrl_reg.control_pe2fu_2;
  assign write_back      = ctrl_reg.wb_en;
  assign ld              = ctrl_reg.ld;
  assign ld_write        = ctrl_reg.ld_write;

  assign busy            = (state_reg == ST_RUN);
  assign done            = done_reg;
  assign cfg_err         = cfg_err_reg;

endmodule
